// File: rtl/bsg_dmc_pkg.sv
// Shared DMC definitions: app command encodings, traffic-generator FSM states
// and the pattern LFSR step used by write and check generators.
package bsg_dmc_pkg;

    typedef enum logic [2:0] {
        WR = 3'b000,
        RD = 3'b001
    } app_cmd_e;

    typedef enum logic [2:0] {
        TG_IDLE     = 3'd0,
        TG_WR_CMD   = 3'd1,
        TG_WR_DATA  = 3'd2,
        TG_RD_CMD   = 3'd3,
        TG_RD_DRAIN = 3'd4,
        TG_DONE     = 3'd5
    } tg_state_e;

    localparam logic [31:0] bsg_dmc_tg_lfsr_taps_gp = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] bsg_dmc_tg_lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? bsg_dmc_tg_lfsr_taps_gp : 32'h0);
    endfunction

endpackage

// File: rtl/bsg_dmc_pattern_gen.sv
// Pseudo-random beat source: a 32-bit Galois LFSR whose state is replicated
// across the beat width. load_i reseeds, yumi_i advances to the next value.
module bsg_dmc_pattern_gen
    import bsg_dmc_pkg::*;
#(
    parameter int width_p = 128
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [31:0]        seed_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            // An all-zero LFSR never leaves zero, so a zero seed becomes 1.
            state_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
        end else if (yumi_i) begin
            state_d = bsg_dmc_tg_lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= 32'h1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < width_p; i++) begin
            data_o[i] = state_q[i % 32];
        end
    end

endmodule

// File: rtl/bsg_dmc_ui_traffic_gen.sv
// UI-side traffic generator: writes N pseudo-random bursts, reads them back
// and counts beats that disagree with the regenerated pattern.
module bsg_dmc_ui_traffic_gen
    import bsg_dmc_pkg::*;
#(
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 128,
    parameter int burst_data_width_p = 256,
    parameter int num_txn_width_p    = 16,
    parameter int addr_stride_p      = burst_data_width_p >> 3
) (
    input  logic                         ui_clk_i,
    input  logic                         ui_clk_sync_rst_i,
    input  logic                         dfi_init_calib_complete_i,

    input  logic                         start_i,
    input  logic [num_txn_width_p-1:0]   num_txn_i,
    input  logic [ui_addr_width_p-1:0]   base_addr_i,
    input  logic [31:0]                  seed_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [15:0]                  error_count_o,

    output logic [ui_addr_width_p-1:0]   app_addr_o,
    output app_cmd_e                     app_cmd_o,
    output logic                         app_en_o,
    input  logic                         app_rdy_i,

    output logic                         app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]   app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0] app_wdf_mask_o,
    output logic                         app_wdf_end_o,
    input  logic                         app_wdf_rdy_i,

    input  logic                         app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]   app_rd_data_i,
    input  logic                         app_rd_data_end_i,

    output logic                         app_ref_req_o,
    output logic                         app_zq_req_o,
    output logic                         app_sr_req_o
);

    // Handshakes: a command transfers on a cycle with app_en_o && app_rdy_i,
    // a write beat on app_wdf_wren_o && app_wdf_rdy_i; an offered item holds
    // every field stable until it transfers. Read beats have no back-pressure.

    localparam int burst_len_lp = burst_data_width_p / ui_data_width_p;
    localparam int beat_w_lp    = (burst_len_lp > 1) ? $clog2(burst_len_lp) : 1;
    localparam logic [beat_w_lp-1:0]       last_beat_lp = beat_w_lp'(burst_len_lp - 1);
    localparam logic [ui_addr_width_p-1:0] stride_lp    = ui_addr_width_p'(addr_stride_p);

    tg_state_e                   state_q;
    logic [num_txn_width_p-1:0]  num_q, t_q, rtxn_q;
    logic [ui_addr_width_p-1:0]  base_q, app_addr_q;
    app_cmd_e                    app_cmd_q;
    logic                        app_en_q, wren_q, wend_q;
    logic [ui_data_width_p-1:0]  wdata_q;
    logic [beat_w_lp-1:0]        wbeat_q, rbeat_q;
    logic                        busy_q, done_q, error_q;
    logic [15:0]                 error_count_q;

    logic                        start_accept, rd_active, rd_beat_last, rd_mismatch;
    logic                        t_last, cmd_fire, wdf_fire, wbeat_last;
    logic                        wr_yumi, chk_yumi;
    logic [num_txn_width_p-1:0]  rd_txn_next;
    logic [ui_data_width_p-1:0]  wr_data, chk_data;

    assign start_accept = ((state_q == TG_IDLE) || (state_q == TG_DONE))
                          && start_i && dfi_init_calib_complete_i;
    assign rd_active    = (state_q == TG_RD_CMD) || (state_q == TG_RD_DRAIN);
    assign rd_beat_last = (rbeat_q == last_beat_lp);
    assign rd_mismatch  = (app_rd_data_i != chk_data) || (app_rd_data_end_i != rd_beat_last);
    assign rd_txn_next  = rtxn_q
                          + num_txn_width_p'(app_rd_data_valid_i && rd_active && rd_beat_last);
    assign t_last       = (t_q == (num_q - num_txn_width_p'(1)));
    assign cmd_fire     = app_en_q && app_rdy_i;
    assign wdf_fire     = wren_q && app_wdf_rdy_i;
    assign wbeat_last   = (wbeat_q == last_beat_lp);

    // The write generator advances whenever its current value is captured
    // into the beat register, so the next beat is ready with no bubble.
    assign wr_yumi  = ((state_q == TG_WR_CMD) && cmd_fire)
                      || ((state_q == TG_WR_DATA) && wdf_fire && !wbeat_last);
    assign chk_yumi = app_rd_data_valid_i && rd_active;

    bsg_dmc_pattern_gen #(.width_p(ui_data_width_p)) wr_gen (
        .clk_i   (ui_clk_i),
        .reset_i (ui_clk_sync_rst_i),
        .load_i  (start_accept),
        .seed_i  (seed_i),
        .yumi_i  (wr_yumi),
        .data_o  (wr_data)
    );

    bsg_dmc_pattern_gen #(.width_p(ui_data_width_p)) chk_gen (
        .clk_i   (ui_clk_i),
        .reset_i (ui_clk_sync_rst_i),
        .load_i  (start_accept),
        .seed_i  (seed_i),
        .yumi_i  (chk_yumi),
        .data_o  (chk_data)
    );

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) begin
            state_q       <= TG_IDLE;
            num_q         <= '0;
            t_q           <= '0;
            rtxn_q        <= '0;
            base_q        <= '0;
            app_addr_q    <= '0;
            app_cmd_q     <= WR;
            app_en_q      <= 1'b0;
            wren_q        <= 1'b0;
            wend_q        <= 1'b0;
            wdata_q       <= '0;
            wbeat_q       <= '0;
            rbeat_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_count_q <= '0;
        end else begin
            // Read checking; stray beats outside the read phase are errors too.
            if (app_rd_data_valid_i) begin
                if (rd_active) begin
                    rbeat_q <= rd_beat_last ? '0 : rbeat_q + beat_w_lp'(1);
                    rtxn_q  <= rd_txn_next;
                end
                if (!rd_active || rd_mismatch) begin
                    error_q <= 1'b1;
                    if (error_count_q != 16'hFFFF) begin
                        error_count_q <= error_count_q + 16'd1;
                    end
                end
            end

            case (state_q)
                TG_IDLE, TG_DONE: begin
                    if (start_accept) begin
                        num_q         <= num_txn_i;
                        base_q        <= base_addr_i;
                        t_q           <= '0;
                        rtxn_q        <= '0;
                        wbeat_q       <= '0;
                        rbeat_q       <= '0;
                        error_q       <= 1'b0;
                        error_count_q <= '0;
                        if (num_txn_i == '0) begin
                            state_q <= TG_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= TG_WR_CMD;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            app_en_q   <= 1'b1;
                            app_cmd_q  <= WR;
                            app_addr_q <= base_addr_i;
                        end
                    end
                end

                TG_WR_CMD: begin
                    if (cmd_fire) begin
                        state_q  <= TG_WR_DATA;
                        app_en_q <= 1'b0;
                        wren_q   <= 1'b1;
                        wdata_q  <= wr_data;
                        wend_q   <= (last_beat_lp == '0);
                        wbeat_q  <= '0;
                    end
                end

                TG_WR_DATA: begin
                    if (wdf_fire) begin
                        if (wbeat_last) begin
                            wren_q   <= 1'b0;
                            wend_q   <= 1'b0;
                            app_en_q <= 1'b1;
                            if (t_last) begin
                                state_q    <= TG_RD_CMD;
                                t_q        <= '0;
                                app_cmd_q  <= RD;
                                app_addr_q <= base_q;
                            end else begin
                                state_q    <= TG_WR_CMD;
                                t_q        <= t_q + num_txn_width_p'(1);
                                app_addr_q <= app_addr_q + stride_lp;
                            end
                        end else begin
                            wbeat_q <= wbeat_q + beat_w_lp'(1);
                            wdata_q <= wr_data;
                            wend_q  <= ((wbeat_q + beat_w_lp'(1)) == last_beat_lp);
                        end
                    end
                end

                TG_RD_CMD: begin
                    if (cmd_fire) begin
                        if (t_last) begin
                            state_q  <= TG_RD_DRAIN;
                            app_en_q <= 1'b0;
                            t_q      <= '0;
                        end else begin
                            t_q        <= t_q + num_txn_width_p'(1);
                            app_addr_q <= app_addr_q + stride_lp;
                        end
                    end
                end

                TG_RD_DRAIN: begin
                    if (rd_txn_next >= num_q) begin
                        state_q <= TG_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= TG_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign error_count_o  = error_count_q;
    assign app_addr_o     = app_addr_q;
    assign app_cmd_o      = app_cmd_q;
    assign app_en_o       = app_en_q;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_data_o = wdata_q;
    assign app_wdf_mask_o = '0;
    assign app_wdf_end_o  = wend_q;
    assign app_ref_req_o  = 1'b0;
    assign app_zq_req_o   = 1'b0;
    assign app_sr_req_o   = 1'b0;

endmodule
